// File: rtl/uart_transmitter.sv
// UART transmit path: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Each bit lasts 'prescale' clock cycles. TX_OUT and busy come straight from flops.
module uart_transmitter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [DATA_WIDTH-1:0]       P_DATA,
  input  logic                        Data_Valid,
  input  logic                        PAR_EN,
  input  logic                        PAR_TYP,
  input  logic [$clog2(PRESCALE):0]   prescale,
  output logic                        TX_OUT,
  output logic                        busy
);

  localparam int unsigned PW = $clog2(PRESCALE) + 1;
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  state_e                  state_q;
  logic [PW-1:0]           pre_q;
  logic [PW-1:0]           cnt_q;
  logic [BW-1:0]           bit_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    tx_q;
  logic                    busy_q;

  logic                    bit_done;
  logic                    last_bit;
  logic [DATA_WIDTH-1:0]   shift_nxt;

  always_comb begin
    bit_done  = (cnt_q == (pre_q - PW'(1)));
    last_bit  = (bit_q == BW'(DATA_WIDTH - 1));
    shift_nxt = shift_q >> 1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      pre_q     <= PW'(1);
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      if (state_q != StIdle) begin
        cnt_q <= bit_done ? '0 : cnt_q + PW'(1);
      end
      case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
          bit_q  <= '0;
          if (Data_Valid) begin
            shift_q   <= P_DATA;
            par_en_q  <= PAR_EN;
            // Parity is fixed at accept so later input changes cannot alter it.
            par_bit_q <= (^P_DATA) ^ PAR_TYP;
            pre_q     <= (prescale == '0) ? PW'(1) : prescale;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (bit_done) begin
            tx_q    <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (bit_done) begin
            shift_q <= shift_nxt;
            if (last_bit) begin
              bit_q <= '0;
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= StParity;
              end else begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              bit_q <= bit_q + BW'(1);
              tx_q  <= shift_nxt[0];
            end
          end
        end
        StParity: begin
          if (bit_done) begin
            tx_q    <= 1'b1;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (bit_done) begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          bit_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
